oc_gpio_sequencer: RTL and testbench
====================================

# oc_gpio_sequencer

Programmable step sequencer that drives a bank of GPIO pins from a small pattern table, optionally waiting on a GPIO input between steps. It sits between the control plane and the GPIO pads, alongside the CSR-mapped GPIO block. It produces timed bit-bang sequences such as power-up strobes, reset pulses and handshakes without software timing.

## Interface
- GpioCount, 8: pins driven/sampled, 1..32
- Steps, 16: pattern table depth, power of 2, 2..256; StepW = $clog2(Steps)
- HoldWidth, 16: per-step hold/timeout counter width, 1..32
- SyncCycles, 2: gpioIn synchronizer depth, >=2
- PinW = max(1,$clog2(GpioCount)); EntryW = 2*GpioCount + HoldWidth + 2 + PinW
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- stepWrite  in  1  table write strobe; ignored while busy
- stepAddr  in  StepW  table entry written
- stepData  in  EntryW  entry, LSB first: out[G], drive[G], hold[HoldWidth], wait, waitLevel, waitPin[PinW]
- lastStep  in  StepW  index of final step; sampled at start
- loopCount  in  8  extra passes; 0 = run once, N = N+1 passes; sampled at start
- start  in  1  begin sequence; ignored while busy
- abort  in  1  stop immediately; priority over start and sequencing
- busy  out  1  sequence active
- done  out  1  one-cycle pulse at normal or timeout completion
- error  out  1  sticky wait-timeout flag; cleared by accepted start
- stepIndex  out  StepW  current step (0 when idle)
- gpioOut  out  GpioCount  pin output value
- gpioTristate  out  GpioCount  1 = pin not driven (= !drive)
- gpioIn  in  GpioCount  asynchronous pin input

## Operation
- Table: Steps x EntryW flops, written at clock edge when stepWrite && !busy; reset leaves contents undefined (no reset on table).
- gpioIn passes through SyncCycles-flop synchronizer; wait logic uses synced value only.
- States: IDLE, RUN, WAIT.
- IDLE: busy=0, gpioOut=0, gpioTristate=all 1, stepIndex=0. Accepted start (start && !abort): latch lastStep/loopCount into loopsLeft/last, clear error, load step 0, go RUN (wait=0) or WAIT (wait=1).
- Step load: gpioOut<=out, gpioTristate<=~drive, counter<=hold, stepIndex<=index.
- RUN: counter decrements each cycle; when counter==0 step ends. Non-wait step lasts exactly hold+1 cycles.
- WAIT: each cycle compare syncIn[waitPin] to waitLevel; match ends the step that cycle. No match and counter==0: timeout -> error=1, done pulse, IDLE. Otherwise decrement. waitPin >= GpioCount never matches (times out).
- Step end, index != last: load index+1. Index == last: loopsLeft==0 -> done pulse, IDLE; else loopsLeft-1, load step 0.
- lastStep > Steps-1 impossible by width; index wraps only via the last-step rule.
- abort (any state): IDLE next edge; outputs return to idle values; no done; error unchanged.
- start while busy ignored; stepWrite while busy ignored (table stable during run).
- Reset asserted mid-sequence: outputs immediately (asynchronously) at idle values, busy=0, done=0, error=0, state IDLE.

## Timing
- Reset values: busy 0, done 0, error 0, stepIndex 0, gpioOut 0, gpioTristate all 1.
- All outputs registered; no combinational path from inputs to outputs.
- Start accepted at edge t: busy=1 and step-0 pins valid from t+1.
- Step transitions back-to-back: no idle cycle between steps or loop passes.
- Final step ends at edge e: at e+1 busy=0, done=1 (one cycle), pins at idle values.
- Wait latency: pin edge to match = SyncCycles cycles + 1 compare cycle; next step pins appear the cycle after match.
- Total run time without waits = passes x sum(hold_i+1) cycles.
- Simultaneous start and abort in IDLE: abort wins, no start.

## Test plan
- Reset: hold reset low, toggle all inputs -> gpioTristate=0xFF, gpioOut=0, busy=0, done=0; release -> unchanged.
- Basic: GpioCount=8; steps 0..2 = (out 0x01,drv 0xFF,hold 3),(0x02,0xFF,0),(0x04,0x0F,9), lastStep=2, loopCount=0 -> pins 0x01 for 4 cycles, 0x02 for 1, 0x04 with tristate 0xF0 for 10; done pulses once at cycle 16 after start; busy high exactly 15 cycles.
- Loop: same table, loopCount=2 -> 3 back-to-back passes, 45 busy cycles, single done.
- Wait match: step 1 wait=1, waitPin=5, level=1, hold=100; raise gpioIn[5] 20 cycles into step -> step ends SyncCycles+1 cycles after edge, error=0.
- Wait timeout: same, gpioIn[5] held 0 -> step lasts 101 cycles, done=1, error=1 sticky; next start clears error.
- Abort/ignore: abort mid-step 2 -> next cycle idle pins, no done; start and stepWrite during busy -> no effect on sequence or table readback by rerun.

Source files
------------

// File: rtl/oc_gpio_sequencer.sv
// Table-driven GPIO step sequencer: plays timed pin patterns from a small step table,
// optionally stalling a step until a synchronized GPIO input reaches a level.
module oc_gpio_sequencer #(
  parameter int unsigned GpioCount  = 8,
  parameter int unsigned Steps      = 16,
  parameter int unsigned HoldWidth  = 16,
  parameter int unsigned SyncCycles = 2,
  localparam int unsigned StepW     = $clog2(Steps),
  localparam int unsigned PinW      = (GpioCount > 1) ? $clog2(GpioCount) : 1,
  localparam int unsigned EntryW    = 2 * GpioCount + HoldWidth + 2 + PinW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 step_write_i,
  input  logic [StepW-1:0]     step_addr_i,
  input  logic [EntryW-1:0]    step_data_i,
  input  logic [StepW-1:0]     last_step_i,
  input  logic [7:0]           loop_count_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [StepW-1:0]     step_index_o,
  output logic [GpioCount-1:0] gpio_out_o,
  output logic [GpioCount-1:0] gpio_tristate_o,
  input  logic [GpioCount-1:0] gpio_in_i
);

  localparam int unsigned OffDrv  = GpioCount;
  localparam int unsigned OffHold = 2 * GpioCount;
  localparam int unsigned OffWait = OffHold + HoldWidth;
  localparam int unsigned OffLvl  = OffWait + 1;
  localparam int unsigned OffPin  = OffWait + 2;

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e                 state_q, state_d;
  logic [HoldWidth-1:0]   counter_q, counter_d;
  logic [StepW-1:0]       idx_q, idx_d;
  logic [StepW-1:0]       last_q, last_d;
  logic [7:0]             loops_q, loops_d;
  logic [GpioCount-1:0]   out_q, out_d;
  logic [GpioCount-1:0]   tri_q, tri_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic [EntryW-1:0]      table_q [Steps];
  logic [GpioCount-1:0]   sync_q  [SyncCycles];
  logic [GpioCount-1:0]   sync_in;

  logic                   cur_lvl;
  logic [PinW-1:0]        cur_pin;
  logic                   match;
  logic                   load, step_end, go_idle;
  logic [StepW-1:0]       load_idx;
  logic [EntryW-1:0]      load_entry;

  // Table has no reset; writes are locked out while a sequence is running.
  always_ff @(posedge clk_i) begin
    if (step_write_i && (state_q == StIdle)) begin
      table_q[step_addr_i] <= step_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SyncCycles); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < int'(SyncCycles); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_in = sync_q[SyncCycles-1];
  assign cur_lvl = table_q[idx_q][OffLvl];
  assign cur_pin = table_q[idx_q][OffPin +: PinW];

  // Pins beyond GpioCount never match, so such a wait always times out.
  always_comb begin
    match = 1'b0;
    if (int'(cur_pin) < int'(GpioCount)) match = (sync_in[cur_pin] == cur_lvl);
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    idx_d      = idx_q;
    last_d     = last_q;
    loops_d    = loops_q;
    out_d      = out_q;
    tri_d      = tri_q;
    done_d     = 1'b0;
    error_d    = error_q;
    load       = 1'b0;
    load_idx   = '0;
    step_end   = 1'b0;
    go_idle    = 1'b0;
    load_entry = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          loops_d = loop_count_i;
          last_d  = last_step_i;
          error_d = 1'b0;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (counter_q == '0) step_end = 1'b1;
        else                 counter_d = counter_q - 1'b1;
      end
      StWait: begin
        if (match) begin
          step_end = 1'b1;
        end else if (counter_q == '0) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          go_idle = 1'b1;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (step_end) begin
      if (idx_q != last_q) begin
        load     = 1'b1;
        load_idx = idx_q + 1'b1;
      end else if (loops_q == '0) begin
        done_d  = 1'b1;
        go_idle = 1'b1;
      end else begin
        loops_d = loops_q - 1'b1;
        load    = 1'b1;
      end
    end

    if (load) begin
      load_entry = table_q[load_idx];
      out_d      = load_entry[GpioCount-1:0];
      tri_d      = ~load_entry[OffDrv +: GpioCount];
      counter_d  = load_entry[OffHold +: HoldWidth];
      idx_d      = load_idx;
      state_d    = load_entry[OffWait] ? StWait : StRun;
    end

    if (go_idle) begin
      state_d = StIdle;
      out_d   = '0;
      tri_d   = '1;
      idx_d   = '0;
    end

    // Abort beats start and sequencing; it never signals done or touches error.
    if (abort_i) begin
      state_d = StIdle;
      out_d   = '0;
      tri_d   = '1;
      idx_d   = '0;
      done_d  = 1'b0;
      error_d = error_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      counter_q <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      loops_q   <= '0;
      out_q     <= '0;
      tri_q     <= '1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      loops_q   <= loops_d;
      out_q     <= out_d;
      tri_q     <= tri_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign step_index_o    = idx_q;
  assign gpio_out_o      = out_q;
  assign gpio_tristate_o = tri_q;

endmodule

// File: tb/tb_oc_gpio_sequencer.sv
// Directed bench for oc_gpio_sequencer: table-driven basic run plus hand sequences for
// looping, wait match/timeout, abort, busy lockout and reset.
module tb_oc_gpio_sequencer;

  localparam int unsigned SyncCycles = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        step_write_i;
  logic [3:0]  step_addr_i;
  logic [36:0] step_data_i;
  logic [3:0]  last_step_i;
  logic [7:0]  loop_count_i;
  logic        start_i, abort_i;
  logic        busy_o, done_o, error_o;
  logic [3:0]  step_index_o;
  logic [7:0]  gpio_out_o, gpio_tristate_o, gpio_in_i;

  int n_checks = 0;
  int n_fail   = 0;

  oc_gpio_sequencer #(
    .GpioCount (8),
    .Steps     (16),
    .HoldWidth (16),
    .SyncCycles(SyncCycles)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .step_write_i   (step_write_i),
    .step_addr_i    (step_addr_i),
    .step_data_i    (step_data_i),
    .last_step_i    (last_step_i),
    .loop_count_i   (loop_count_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .step_index_o   (step_index_o),
    .gpio_out_o     (gpio_out_o),
    .gpio_tristate_o(gpio_tristate_o),
    .gpio_in_i      (gpio_in_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    int unsigned reps;
    logic        busy;
    logic        done;
    logic [7:0]  out;
    logic [7:0]  pin_tri;
    logic [3:0]  idx;
  } row_t;

  row_t rows[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [36:0] entry(input logic [7:0] out, input logic [7:0] drv,
                                        input logic [15:0] hold, input logic wt,
                                        input logic lvl, input logic [2:0] pin);
    return {pin, lvl, wt, hold, drv, out};
  endfunction

  task automatic write_step(input logic [3:0] addr, input logic [36:0] data);
    step_write_i = 1'b1;
    step_addr_i  = addr;
    step_data_i  = data;
    tick();
    step_write_i = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".busy"}, 64'(busy_o), 64'd0);
    chk({name, ".out"},  64'(gpio_out_o), 64'h00);
    chk({name, ".tri"},  64'(gpio_tristate_o), 64'hFF);
    chk({name, ".idx"},  64'(step_index_o), 64'd0);
  endtask

  task automatic run_rows(input string name);
    for (int r = 0; r < 6; r++) begin
      for (int unsigned k = 0; k < rows[r].reps; k++) begin
        chk({name, ".busy"}, 64'(busy_o), 64'(rows[r].busy));
        chk({name, ".done"}, 64'(done_o), 64'(rows[r].done));
        chk({name, ".out"},  64'(gpio_out_o), 64'(rows[r].out));
        chk({name, ".tri"},  64'(gpio_tristate_o), 64'(rows[r].pin_tri));
        chk({name, ".idx"},  64'(step_index_o), 64'(rows[r].idx));
        start_i = rows[r].start;
        tick();
      end
    end
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!done_o && n < bound) begin
      tick();
      n++;
    end
    chk({name, ".done_seen"}, 64'(done_o), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, b;
    rows[0] = '{1'b1, 1,  1'b0, 1'b0, 8'h00, 8'hFF, 4'd0};
    rows[1] = '{1'b0, 4,  1'b1, 1'b0, 8'h01, 8'h00, 4'd0};
    rows[2] = '{1'b0, 1,  1'b1, 1'b0, 8'h02, 8'h00, 4'd1};
    rows[3] = '{1'b0, 10, 1'b1, 1'b0, 8'h04, 8'hF0, 4'd2};
    rows[4] = '{1'b0, 1,  1'b0, 1'b1, 8'h00, 8'hFF, 4'd0};
    rows[5] = '{1'b0, 1,  1'b0, 1'b0, 8'h00, 8'hFF, 4'd0};

    rst_ni = 1'b0; step_write_i = 0; step_addr_i = 0; step_data_i = 0;
    last_step_i = 0; loop_count_i = 0; start_i = 0; abort_i = 0; gpio_in_i = 0;

    // Reset held: inputs wiggle, outputs stay idle.
    for (int i = 0; i < 4; i++) begin
      tick();
      start_i = 1'($urandom); abort_i = 1'($urandom); gpio_in_i = 8'($urandom);
      last_step_i = 4'($urandom); loop_count_i = 8'($urandom);
      chk_idle("reset");
      chk("reset.done", 64'(done_o), 64'd0);
      chk("reset.error", 64'(error_o), 64'd0);
    end
    tick();
    start_i = 0; abort_i = 0; gpio_in_i = 0; last_step_i = 0; loop_count_i = 0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk_idle("post_reset");
    chk("post_reset.done", 64'(done_o), 64'd0);

    write_step(4'd0, entry(8'h01, 8'hFF, 16'd3, 1'b0, 1'b0, 3'd0));
    write_step(4'd1, entry(8'h02, 8'hFF, 16'd0, 1'b0, 1'b0, 3'd0));
    write_step(4'd2, entry(8'h04, 8'h0F, 16'd9, 1'b0, 1'b0, 3'd0));
    last_step_i = 4'd2;
    loop_count_i = 8'd0;
    tick();
    run_rows("basic");

    // Three back-to-back passes.
    loop_count_i = 8'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    loop_count_i = 8'd0;
    for (int k = 0; k < 45; k++) begin
      chk("loop.busy", 64'(busy_o), 64'd1);
      chk("loop.done", 64'(done_o), 64'd0);
      chk("loop.out", 64'(gpio_out_o), ((k % 15) < 4) ? 64'h01 : ((k % 15) == 4) ? 64'h02 : 64'h04);
      tick();
    end
    chk("loop.end_busy", 64'(busy_o), 64'd0);
    chk("loop.end_done", 64'(done_o), 64'd1);
    tick();
    chk("loop.done_pulse", 64'(done_o), 64'd0);

    // Wait match on pin 5.
    write_step(4'd1, entry(8'h02, 8'hFF, 16'd100, 1'b1, 1'b1, 3'd5));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    chk("wmatch.in_step1", 64'(step_index_o), 64'd1);
    repeat (19) tick();
    gpio_in_i[5] = 1'b1;
    for (int k = 0; k < int'(SyncCycles); k++) begin
      tick();
      chk("wmatch.still_step1", 64'(step_index_o), 64'd1);
    end
    tick();
    chk("wmatch.step2_idx", 64'(step_index_o), 64'd2);
    chk("wmatch.step2_out", 64'(gpio_out_o), 64'h04);
    wait_done("wmatch", 50);
    chk("wmatch.error", 64'(error_o), 64'd0);
    gpio_in_i = 8'h00;
    repeat (3) tick();

    // Wait timeout.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (step_index_o != 4'd1 && n < 20) begin tick(); n++; end
    n = 0;
    while (step_index_o == 4'd1 && busy_o && n < 200) begin tick(); n++; end
    chk("tmo.step_len", 64'(n), 64'd101);
    chk("tmo.done", 64'(done_o), 64'd1);
    chk("tmo.error", 64'(error_o), 64'd1);
    chk_idle("tmo");
    tick();
    chk("tmo.done_pulse", 64'(done_o), 64'd0);
    chk("tmo.error_sticky", 64'(error_o), 64'd1);

    // Abort wins over start in idle; error untouched.
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_start.busy", 64'(busy_o), 64'd0);
    chk("abort_start.error", 64'(error_o), 64'd1);

    gpio_in_i[5] = 1'b1;
    repeat (3) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart.error_clr", 64'(error_o), 64'd0);
    chk("restart.busy", 64'(busy_o), 64'd1);
    wait_done("restart", 50);
    gpio_in_i = 8'h00;
    write_step(4'd1, entry(8'h02, 8'hFF, 16'd0, 1'b0, 1'b0, 3'd0));
    tick();

    // Start and table write while busy are ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    b = 0;
    while (busy_o && b < 100) begin
      b++;
      if (b == 2) begin
        start_i = 1'b1; step_write_i = 1'b1; step_addr_i = 4'd0;
        step_data_i = entry(8'hAA, 8'hFF, 16'd7, 1'b0, 1'b0, 3'd0);
      end else begin
        start_i = 1'b0; step_write_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0; step_write_i = 1'b0;
    chk("ignore.busy_len", 64'(b), 64'd15);
    chk("ignore.done", 64'(done_o), 64'd1);
    tick();
    run_rows("rerun");

    // Abort mid step 2.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (step_index_o != 4'd2 && n < 20) begin tick(); n++; end
    repeat (2) tick();
    chk("abort.pre_idx", 64'(step_index_o), 64'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_idle("abort");
    chk("abort.done", 64'(done_o), 64'd0);
    chk("abort.error", 64'(error_o), 64'd0);
    repeat (10) begin
      tick();
      chk("abort.no_done", 64'(done_o), 64'd0);
    end

    // Asynchronous reset mid-sequence.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    chk("areset.pre_busy", 64'(busy_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk_idle("areset");
    chk("areset.done", 64'(done_o), 64'd0);
    chk("areset.error", 64'(error_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk_idle("areset_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
